// File: rtl/tpu_operand_loader.sv
// Streams row-major int8 matrices A then B into the tiled global buffers used by
// the systolic engine, packing TILE elements per word and zero-filling partial tiles.
module tpu_operand_loader #(
   parameter int TILE = 4,
   parameter int AW   = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cfg_valid,
   input  logic [7:0]    K,
   input  logic [7:0]    M,
   input  logic [7:0]    N,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          A_wr_en,
   output logic [AW-1:0] A_index,
   output logic [31:0]   A_data_in,
   output logic          B_wr_en,
   output logic [AW-1:0] B_index,
   output logic [31:0]   B_data_in,
   output logic          busy,
   output logic          load_done,
   output logic          cfg_err
);
   // state    | meaning
   // S_IDLE   | waiting for a legal cfg_valid
   // S_LOAD_A | accepting A elements, writing buffer A
   // S_PAD_A  | zero words for rows M..4*Mt-1 of A
   // S_LOAD_B | accepting B elements, writing buffer B
   // S_PAD_B  | zero words for rows K..4*Kt-1 of B
   // S_DONE   | pulse load_done, drop busy

   localparam int TB = $clog2(TILE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_PAD_A,
      S_LOAD_B,
      S_PAD_B,
      S_DONE
   } state_t;

   state_t      r_state;
   logic [7:0]  r_k;
   logic [7:0]  r_m;
   logic [7:0]  r_n;
   logic [7:0]  r_row;
   logic [7:0]  r_col;
   logic [31:0] r_pack;

   logic          w_is_a;
   logic          w_is_pad;
   logic          w_accept;
   logic [7:0]    w_kt;
   logic [7:0]    w_nt;
   logic [7:0]    w_len;
   logic [7:0]    w_rows;
   logic [7:0]    w_pad_grps;
   logic [TB-1:0] w_byte;
   logic          w_last_col;
   logic          w_last_row;
   logic          w_word_end;
   logic          w_pad_needed;
   logic          w_tile_row_end;
   logic [31:0]   w_word;
   logic [AW-1:0] w_row_tile;
   logic [AW-1:0] w_row_sub;
   logic [AW-1:0] w_grp;
   logic [AW-1:0] w_kt_ext;
   logic [AW-1:0] w_a_idx;
   logic [AW-1:0] w_b_idx;
   state_t        w_after_phase;

   assign in_ready = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
   assign w_accept = in_valid && in_ready;
   assign w_is_a   = (r_state == S_LOAD_A) || (r_state == S_PAD_A);
   assign w_is_pad = (r_state == S_PAD_A) || (r_state == S_PAD_B);

   // Tile counts widened by one bit so dimensions near 255 do not wrap.
   assign w_kt = 8'(({1'b0, r_k} + 9'(TILE - 1)) >> TB);
   assign w_nt = 8'(({1'b0, r_n} + 9'(TILE - 1)) >> TB);

   assign w_len      = w_is_a ? r_k : r_n;
   assign w_rows     = w_is_a ? r_m : r_k;
   assign w_pad_grps = w_is_a ? w_kt : w_nt;

   assign w_byte         = r_col[TB-1:0];
   assign w_last_col     = (r_col == w_len - 8'd1);
   assign w_last_row     = (r_row == w_rows - 8'd1);
   assign w_word_end     = (w_byte == TB'(TILE - 1)) || w_last_col;
   assign w_pad_needed   = (w_rows[TB-1:0] != '0);
   assign w_tile_row_end = (r_row[TB-1:0] == TB'(TILE - 1));
   assign w_after_phase  = w_is_a ? S_LOAD_B : S_DONE;

   // In PAD states r_col counts column groups directly rather than elements.
   assign w_row_tile = AW'(r_row >> TB);
   assign w_row_sub  = AW'(r_row[TB-1:0]);
   assign w_grp      = w_is_pad ? AW'(r_col) : AW'(r_col >> TB);
   assign w_kt_ext   = AW'(w_kt);
   assign w_a_idx    = ((w_row_tile * w_kt_ext + w_grp) << TB) + w_row_sub;
   assign w_b_idx    = ((w_grp * w_kt_ext + w_row_tile) << TB) + w_row_sub;

   always_comb begin
      w_word = '0;
      for (int i = 0; i < TILE; i++) begin
         if (i < int'(w_byte))
            w_word[8*i +: 8] = r_pack[8*i +: 8];
         else if (i == int'(w_byte))
            w_word[8*i +: 8] = in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_k       <= '0;
         r_m       <= '0;
         r_n       <= '0;
         r_row     <= '0;
         r_col     <= '0;
         r_pack    <= '0;
         A_wr_en   <= 1'b0;
         A_index   <= '0;
         A_data_in <= '0;
         B_wr_en   <= 1'b0;
         B_index   <= '0;
         B_data_in <= '0;
         busy      <= 1'b0;
         load_done <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         A_wr_en   <= 1'b0;
         B_wr_en   <= 1'b0;
         load_done <= 1'b0;
         cfg_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cfg_valid) begin
                  if (K == 8'd0 || M == 8'd0 || N == 8'd0) begin
                     cfg_err <= 1'b1;
                  end else begin
                     r_k     <= K;
                     r_m     <= M;
                     r_n     <= N;
                     r_row   <= '0;
                     r_col   <= '0;
                     busy    <= 1'b1;
                     r_state <= S_LOAD_A;
                  end
               end
            end
            S_LOAD_A, S_LOAD_B: begin
               if (w_accept) begin
                  r_pack[{w_byte, 3'b000} +: 8] <= in_data;
                  if (w_word_end) begin
                     if (w_is_a) begin
                        A_wr_en   <= 1'b1;
                        A_index   <= w_a_idx;
                        A_data_in <= w_word;
                     end else begin
                        B_wr_en   <= 1'b1;
                        B_index   <= w_b_idx;
                        B_data_in <= w_word;
                     end
                  end
                  if (w_last_col) begin
                     r_col <= '0;
                     if (w_last_row) begin
                        if (w_pad_needed) begin
                           r_row   <= w_rows;
                           r_state <= w_is_a ? S_PAD_A : S_PAD_B;
                        end else begin
                           r_row   <= '0;
                           r_state <= w_after_phase;
                        end
                     end else begin
                        r_row <= r_row + 8'd1;
                     end
                  end else begin
                     r_col <= r_col + 8'd1;
                  end
               end
            end
            S_PAD_A, S_PAD_B: begin
               if (w_is_a) begin
                  A_wr_en   <= 1'b1;
                  A_index   <= w_a_idx;
                  A_data_in <= '0;
               end else begin
                  B_wr_en   <= 1'b1;
                  B_index   <= w_b_idx;
                  B_data_in <= '0;
               end
               if (r_col == w_pad_grps - 8'd1) begin
                  r_col <= '0;
                  if (w_tile_row_end) begin
                     r_row   <= '0;
                     r_state <= w_after_phase;
                  end else begin
                     r_row <= r_row + 8'd1;
                  end
               end else begin
                  r_col <= r_col + 8'd1;
               end
            end
            S_DONE: begin
               load_done <= 1'b1;
               busy      <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tpu_operand_loader.sv
// Randomized bench for tpu_operand_loader: streams matrices and compares the
// buffer image written by the DUT against a tiled-layout model of the matrices.
module tb_tpu_operand_loader;
   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_valid;
   logic [7:0]  K, M, N;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        A_wr_en;
   logic [15:0] A_index;
   logic [31:0] A_data_in;
   logic        B_wr_en;
   logic [15:0] B_index;
   logic [31:0] B_data_in;
   logic        busy;
   logic        load_done;
   logic        cfg_err;

   tpu_operand_loader #(.TILE(4), .AW(16)) dut (
      .clk(clk), .reset(reset), .cfg_valid(cfg_valid),
      .K(K), .M(M), .N(N),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .A_wr_en(A_wr_en), .A_index(A_index), .A_data_in(A_data_in),
      .B_wr_en(B_wr_en), .B_index(B_index), .B_data_in(B_data_in),
      .busy(busy), .load_done(load_done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] SENTINEL = 32'hDEADBEEF;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]  a_mat [16][16];
   logic [7:0]  b_mat [16][16];
   logic [31:0] mem_a [256];
   logic [31:0] mem_b [256];
   int          wc_a  [256];
   int          wc_b  [256];
   int n_a, n_b, done_cnt, err_cnt;
   int cyc = 0, cfg_cyc = 0, done_cyc = 0, last_wr_cyc = 0;
   bit prev_stall = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = SENTINEL;
         mem_b[i] = SENTINEL;
         wc_a[i]  = 0;
         wc_b[i]  = 0;
      end
      n_a = 0;
      n_b = 0;
      done_cnt = 0;
      err_cnt  = 0;
   endtask

   always @(negedge clk) begin
      cyc++;
      if (cfg_valid && !busy && !reset) cfg_cyc = cyc;
      if (prev_stall) chk("stall_no_write", {30'd0, A_wr_en, B_wr_en}, 32'd0);
      prev_stall = in_ready && !in_valid && !reset;
      if (A_wr_en) begin
         n_a++;
         last_wr_cyc = cyc;
         if (int'(A_index) < 256) begin
            mem_a[A_index] = A_data_in;
            wc_a[A_index]++;
         end else chk("a_index_range", {16'd0, A_index}, 32'd0);
      end
      if (B_wr_en) begin
         n_b++;
         last_wr_cyc = cyc;
         if (int'(B_index) < 256) begin
            mem_b[B_index] = B_data_in;
            wc_b[B_index]++;
         end else chk("b_index_range", {16'd0, B_index}, 32'd0);
      end
      if (load_done) begin
         done_cnt++;
         done_cyc = cyc;
         chk("done_after_last_wr", last_wr_cyc, cyc - 1);
         chk("busy_low_at_done", {31'd0, busy}, 32'd0);
      end
      if (cfg_err) err_cnt++;
   end

   // Golden image: each word holds 4 consecutive columns of one row, placed at
   // its tile address; elements outside the matrix read as zero.
   task automatic verify(input string tag, input int m, input int k, input int n);
      int mt, kt, nt, idx, col;
      logic [31:0] w;
      mt = (m + 3) / 4;
      kt = (k + 3) / 4;
      nt = (n + 3) / 4;
      chk({tag, "_a_words"}, n_a, mt * kt * 4);
      chk({tag, "_b_words"}, n_b, kt * nt * 4);
      for (int r = 0; r < 4 * mt; r++) begin
         for (int c = 0; c < kt; c++) begin
            w = '0;
            for (int j = 0; j < 4; j++) begin
               col = 4 * c + j;
               if (r < m && col < k) w[8*j +: 8] = a_mat[r][col];
            end
            idx = ((r / 4) * kt + c) * 4 + r % 4;
            chk($sformatf("%s_a%0d_cnt", tag, idx), wc_a[idx], 1);
            chk($sformatf("%s_a%0d_dat", tag, idx), mem_a[idx], w);
         end
      end
      for (int r = 0; r < 4 * kt; r++) begin
         for (int g = 0; g < nt; g++) begin
            w = '0;
            for (int j = 0; j < 4; j++) begin
               col = 4 * g + j;
               if (r < k && col < n) w[8*j +: 8] = b_mat[r][col];
            end
            idx = (g * kt + r / 4) * 4 + r % 4;
            chk($sformatf("%s_b%0d_cnt", tag, idx), wc_b[idx], 1);
            chk($sformatf("%s_b%0d_dat", tag, idx), mem_b[idx], w);
         end
      end
   endtask

   task automatic run_load(input int m, input int k, input int n, input int gap_pct,
                           input int stray_at, input int stop_at);
      int total, w, e2;
      clear_model();
      M = 8'(m);
      K = 8'(k);
      N = 8'(n);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      total = m * k + k * n;
      for (int e = 0; e < total; e++) begin
         if (e == stop_at) return;
         while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            tick();
         end
         if (e < m * k) begin
            in_data = a_mat[e / k][e % k];
         end else begin
            e2 = e - m * k;
            in_data = b_mat[e2 / n][e2 % n];
         end
         in_valid = 1'b1;
         if (e == stray_at) begin
            cfg_valid = 1'b1;
            M = 8'd1;
            K = 8'd1;
            N = 8'd1;
         end
         w = 0;
         while (!in_ready && w < 100) begin
            tick();
            w++;
         end
         if (!in_ready) begin
            chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
            in_valid  = 1'b0;
            cfg_valid = 1'b0;
            return;
         end
         tick();
         cfg_valid = 1'b0;
      end
      in_valid = 1'b0;
      w = 0;
      while (done_cnt == 0 && w < 100) begin
         tick();
         w++;
      end
      tick();
      tick();
      chk("load_done_pulses", done_cnt, 1);
   endtask

   initial begin
      reset = 1'b1;
      cfg_valid = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      K = '0;
      M = '0;
      N = '0;
      clear_model();
      repeat (3) tick();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_wr_en", {30'd0, A_wr_en, B_wr_en}, 32'd0);
      chk("rst_a_index", {16'd0, A_index}, 32'd0);
      chk("rst_b_index", {16'd0, B_index}, 32'd0);
      chk("rst_a_data", A_data_in, 32'd0);
      chk("rst_b_data", B_data_in, 32'd0);
      chk("rst_flags", {30'd0, load_done, cfg_err}, 32'd0);
      reset = 1'b0;
      tick();

      // A = 1..16, B = identity
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            a_mat[r][c] = 8'(r * 4 + c + 1);
            b_mat[r][c] = (r == c) ? 8'd1 : 8'd0;
         end
      run_load(4, 4, 4, 0, -1, -1);
      chk("t1_a0_word", mem_a[0], 32'h04030201);
      chk("t1_b0_word", mem_b[0], 32'h00000001);
      chk("t1_latency", done_cyc - cfg_cyc - 1, 33);
      verify("t1", 4, 4, 4);

      // Partial tiles on every dimension, all elements 0x7F
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) begin
            a_mat[r][c] = 8'h7F;
            b_mat[r][c] = 8'h7F;
         end
      run_load(5, 3, 2, 0, -1, -1);
      chk("t2_a0_word", mem_a[0], 32'h007F7F7F);
      chk("t2_a4_word", mem_a[4], 32'h007F7F7F);
      chk("t2_a5_pad", mem_a[5], 32'h0);
      chk("t2_a7_pad", mem_a[7], 32'h0);
      chk("t2_b2_word", mem_b[2], 32'h00007F7F);
      chk("t2_b3_pad", mem_b[3], 32'h0);
      chk("t2_a_total", n_a, 8);
      chk("t2_b_total", n_b, 4);
      verify("t2", 5, 3, 2);

      // Random data with random in_valid gaps
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) begin
            a_mat[r][c] = 8'($urandom_range(255));
            b_mat[r][c] = 8'($urandom_range(255));
         end
      run_load(8, 8, 8, 30, -1, -1);
      verify("t3", 8, 8, 8);

      // Zero dimension is rejected
      clear_model();
      M = 8'd4;
      K = 8'd4;
      N = 8'd0;
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      in_valid = 1'b1;
      chk("t4_cfg_err_high", {31'd0, cfg_err}, 32'd1);
      chk("t4_busy", {31'd0, busy}, 32'd0);
      chk("t4_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("t4_cfg_err_low", {31'd0, cfg_err}, 32'd0);
      repeat (5) tick();
      in_valid = 1'b0;
      chk("t4_err_pulses", err_cnt, 1);
      chk("t4_no_writes", n_a + n_b, 0);
      chk("t4_busy_after", {31'd0, busy}, 32'd0);
      chk("t4_ready_after", {31'd0, in_ready}, 32'd0);

      // Reset after 6 A elements, then a clean 4x4x4 load
      run_load(8, 8, 8, 0, -1, 6);
      reset = 1'b1;
      in_valid = 1'b0;
      tick();
      chk("t5_busy", {31'd0, busy}, 32'd0);
      chk("t5_in_ready", {31'd0, in_ready}, 32'd0);
      chk("t5_a_wr_en", {31'd0, A_wr_en}, 32'd0);
      chk("t5_a_data", A_data_in, 32'd0);
      chk("t5_a_index", {16'd0, A_index}, 32'd0);
      reset = 1'b0;
      tick();
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) begin
            a_mat[r][c] = 8'($urandom_range(255));
            b_mat[r][c] = 8'($urandom_range(255));
         end
      run_load(4, 4, 4, 0, -1, -1);
      verify("t5", 4, 4, 4);

      // cfg_valid with new dimensions during LOAD_B is ignored
      run_load(4, 4, 8, 10, 4 * 4 + 3, -1);
      verify("t6", 4, 4, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
